// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
//   EX-stage resolution of conditional branches, JAL and JALR. A taken control
//   transfer produces a registered redirect request to fetch. The request is
//   held under a valid/ack handshake. The wrong-path IF/ID and ID/EX slots are
//   flushed, and saturating counts of resolved and taken transfers are kept.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   ex_valid                      EX slot holds a real instruction
//   ex_branch/ex_jal/ex_jalr      decode of EX instruction (jalr > jal > branch)
//   cmp_taken                     comparator decision for conditional branches
//   ex_pc, ex_imm, ex_rs1         target operands
//   stall                         pipeline hold
//   redirect_ack                  fetch accepted redirect_pc
//   redirect_valid, redirect_pc   redirect request to fetch
//   flush_if_id, flush_id_ex      squash wrong-path pipeline registers
//   misalign_exc                  one-cycle pulse, target bit1 was set
//   branch_cnt, taken_cnt         saturating statistics
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | resolving EX control transfers
// S_REDIR  | redirect_valid held until fetch acks
// S_FLUSH  | post-ack flush cycles, counted down on non-stall cycles
module branch_redirect_ctrl #(
    parameter int                XLEN         = 32,
    parameter int                FLUSH_CYCLES = 2,
    parameter logic [XLEN-1:0]   TRAP_VEC     = XLEN'(32'h0000_0004),
    parameter int                CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             ex_jal,
    input  logic             ex_jalr,
    input  logic             cmp_taken,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic             stall,
    input  logic             redirect_ack,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             misalign_exc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REDIR = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t          state;
    logic [FCW-1:0]  flush_cnt;
    logic            flush_q;

    logic            resolve;
    logic            take;
    logic [XLEN-1:0] sum_base;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] target;
    logic            target_mis;

    assign resolve = ex_valid & ~stall & (state == S_IDLE)
                   & (ex_branch | ex_jal | ex_jalr);
    assign take    = resolve & (ex_jal | ex_jalr | (ex_branch & cmp_taken));

    // JALR uses rs1 as its base and clears bit0; JAL and branches are PC-relative.
    assign sum_base   = ex_jalr ? ex_rs1 : ex_pc;
    assign sum        = sum_base + ex_imm;
    assign target     = ex_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
    assign target_mis = target[1];

    assign flush_if_id = flush_q;
    assign flush_id_ex = flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            flush_cnt      <= '0;
            flush_q        <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            misalign_exc   <= 1'b0;
            branch_cnt     <= '0;
            taken_cnt      <= '0;
        end else begin
            misalign_exc <= 1'b0;

            if (resolve && branch_cnt != CNT_MAX)
                branch_cnt <= branch_cnt + 1'b1;
            if (take && taken_cnt != CNT_MAX)
                taken_cnt <= taken_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (take) begin
                        state          <= S_REDIR;
                        redirect_valid <= 1'b1;
                        flush_q        <= 1'b1;
                        redirect_pc    <= target_mis ? TRAP_VEC : target;
                        misalign_exc   <= target_mis;
                    end
                end
                S_REDIR: begin
                    if (redirect_ack) begin
                        redirect_valid <= 1'b0;
                        if (FLUSH_CYCLES == 1) begin
                            state   <= S_IDLE;
                            flush_q <= 1'b0;
                        end else begin
                            state     <= S_FLUSH;
                            flush_cnt <= FCW'(FLUSH_CYCLES - 1);
                        end
                    end
                end
                S_FLUSH: begin
                    // flush_cnt is the number of flush cycles left, this one included.
                    if (!stall) begin
                        if (flush_cnt <= FCW'(1)) begin
                            state     <= S_IDLE;
                            flush_q   <= 1'b0;
                            flush_cnt <= '0;
                        end else begin
                            flush_cnt <= flush_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state          <= S_IDLE;
                    flush_q        <= 1'b0;
                    redirect_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;

    localparam int          XLEN  = 32;
    localparam int          FC    = 2;
    localparam int          CNT_W = 5;
    localparam logic [31:0] TRAP  = 32'h0000_0004;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ex_valid = 1'b0, ex_branch = 1'b0, ex_jal = 1'b0, ex_jalr = 1'b0;
    logic             cmp_taken = 1'b0;
    logic [XLEN-1:0]  ex_pc = '0, ex_imm = '0, ex_rs1 = '0;
    logic             stall = 1'b0;
    logic             redirect_ack = 1'b0;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush_if_id, flush_id_ex, misalign_exc;
    logic [CNT_W-1:0] branch_cnt, taken_cnt;

    branch_redirect_ctrl #(
        .XLEN(XLEN), .FLUSH_CYCLES(FC), .TRAP_VEC(TRAP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
        .cmp_taken(cmp_taken), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
        .stall(stall), .redirect_ack(redirect_ack),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .misalign_exc(misalign_exc), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a redirect is either outstanding or not, followed by a
    // number of remaining flush cycles; the controller is free only when neither.
    bit          m_pend;
    int          m_fleft;
    logic [31:0] m_pc;
    bit          m_mis;
    int          m_bc, m_tc;
    logic [31:0] m_t;

    always @(posedge clk) begin
        if (rst) begin
            m_pend = 0; m_fleft = 0; m_pc = '0; m_mis = 0; m_bc = 0; m_tc = 0;
        end else begin
            m_mis = 0;
            if (!m_pend && m_fleft == 0) begin
                if (ex_valid && !stall && (ex_branch || ex_jal || ex_jalr)) begin
                    if (m_bc < CMAX) m_bc++;
                    if (ex_jalr || ex_jal || (ex_branch && cmp_taken)) begin
                        if (ex_jalr) m_t = (ex_rs1 + ex_imm) & ~32'h1;
                        else         m_t = ex_pc + ex_imm;
                        m_mis  = m_t[1];
                        m_pc   = m_t[1] ? TRAP : m_t;
                        m_pend = 1;
                        if (m_tc < CMAX) m_tc++;
                    end
                end
            end else if (m_pend) begin
                if (redirect_ack) begin
                    m_pend  = 0;
                    m_fleft = FC - 1;
                end
            end else if (!stall) begin
                m_fleft--;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("redirect_valid", 32'(redirect_valid), 32'(m_pend));
            chk("redirect_pc",    redirect_pc,         m_pc);
            chk("flush_if_id",    32'(flush_if_id),    32'(m_pend || m_fleft > 0));
            chk("flush_id_ex",    32'(flush_id_ex),    32'(m_pend || m_fleft > 0));
            chk("misalign_exc",   32'(misalign_exc),   32'(m_mis));
            chk("branch_cnt",     32'(branch_cnt),     32'(m_bc));
            chk("taken_cnt",      32'(taken_cnt),      32'(m_tc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid = 0; ex_branch = 0; ex_jal = 0; ex_jalr = 0; cmp_taken = 0;
    endtask

    // kind: 0 branch, 1 jal, 2 jalr
    task automatic present(input int kind, input logic [31:0] pc, input logic [31:0] imm,
                           input logic [31:0] rs1, input bit c);
        ex_valid  = 1;
        ex_branch = (kind == 0);
        ex_jal    = (kind == 1);
        ex_jalr   = (kind == 2);
        cmp_taken = c;
        ex_pc = pc; ex_imm = imm; ex_rs1 = rs1;
    endtask

    task automatic issue(input int kind, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input bit c);
        present(kind, pc, imm, rs1, c);
        tick();
        clear_ex();
    endtask

    task automatic ack_done();
        redirect_ack = 1;
        tick();
        redirect_ack = 0;
        tick();
        tick();
    endtask

    initial begin
        tick();
        tick();
        checking = 1'b1;
        rst = 0;
        @(negedge clk);
        chk("reset_valid", 32'(redirect_valid), 32'h0);
        chk("reset_pc",    redirect_pc,         32'h0);
        chk("reset_cnt",   32'(branch_cnt),     32'h0);

        // BEQ taken, ack in the first redirect cycle
        issue(0, 32'h100, 32'h20, 32'h0, 1);
        @(negedge clk);
        chk("beq_pc",    redirect_pc,         32'h120);
        chk("beq_valid", 32'(redirect_valid), 32'h1);
        chk("beq_flush", 32'(flush_if_id),    32'h1);
        redirect_ack = 1;
        tick();
        redirect_ack = 0;
        @(negedge clk);
        chk("beq_valid_drop", 32'(redirect_valid), 32'h0);
        chk("beq_flush_n2",   32'(flush_id_ex),    32'h1);
        tick();
        @(negedge clk);
        chk("beq_flush_end", 32'(flush_if_id), 32'h0);
        chk("beq_taken_cnt", 32'(taken_cnt),   32'h1);

        // BNE not taken
        issue(0, 32'h200, 32'h40, 32'h0, 0);
        @(negedge clk);
        chk("bne_valid",  32'(redirect_valid), 32'h0);
        chk("bne_flush",  32'(flush_if_id),    32'h0);
        chk("bne_branch", 32'(branch_cnt),     32'h2);
        chk("bne_taken",  32'(taken_cnt),      32'h1);

        // JALR: 0x203 -> 0x202 has bit1 set, so the trap vector is used
        issue(2, 32'h0, 32'h0, 32'h203, 0);
        @(negedge clk);
        chk("jalr_mis_pc",  redirect_pc,       TRAP);
        chk("jalr_mis_exc", 32'(misalign_exc), 32'h1);
        redirect_ack = 1;
        tick();
        redirect_ack = 0;
        @(negedge clk);
        chk("jalr_mis_pulse", 32'(misalign_exc), 32'h0);
        tick();
        tick();
        issue(2, 32'h0, 32'h0, 32'h201, 0);
        @(negedge clk);
        chk("jalr_pc",  redirect_pc,       32'h200);
        chk("jalr_exc", 32'(misalign_exc), 32'h0);
        ack_done();

        // JAL wrap and JAL misaligned
        issue(1, 32'hFFFF_FFF0, 32'h20, 32'h0, 0);
        @(negedge clk);
        chk("jal_wrap_pc", redirect_pc, 32'h10);
        ack_done();
        issue(1, 32'h100, 32'h6, 32'h0, 0);
        @(negedge clk);
        chk("jal_mis_pc",  redirect_pc,       TRAP);
        chk("jal_mis_exc", 32'(misalign_exc), 32'h1);
        ack_done();

        // JAL and JALR both decoded: JALR target wins
        present(1, 32'h1000, 32'h10, 32'h2000, 0);
        ex_jalr = 1;
        tick();
        clear_ex();
        @(negedge clk);
        chk("prio_pc", redirect_pc, 32'h2010);
        ack_done();

        // Withheld ack, stall in flush, wrong-path JAL ignored
        issue(1, 32'h300, 32'h40, 32'h0, 0);
        present(1, 32'h500, 32'h8, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("hold_valid", 32'(redirect_valid), 32'h1);
            chk("hold_pc",    redirect_pc,         32'h340);
        end
        redirect_ack = 1;
        tick();
        redirect_ack = 0;
        stall = 1;
        @(negedge clk);
        chk("f5_valid", 32'(redirect_valid), 32'h0);
        chk("f5_flush1", 32'(flush_if_id),   32'h1);
        tick();
        @(negedge clk);
        chk("f5_flush2", 32'(flush_if_id), 32'h1);
        tick();
        stall = 0;
        @(negedge clk);
        chk("f5_flush3", 32'(flush_if_id), 32'h1);
        tick();
        clear_ex();
        @(negedge clk);
        chk("f5_idle_flush", 32'(flush_if_id), 32'h0);
        chk("f5_taken",      32'(taken_cnt),   32'h7);
        chk("f5_branch",     32'(branch_cnt),  32'h8);

        // Reset while a redirect is pending
        issue(1, 32'h40, 32'h40, 32'h0, 0);
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        chk("rst_valid", 32'(redirect_valid), 32'h0);
        chk("rst_pc",    redirect_pc,         32'h0);
        chk("rst_flush", 32'(flush_id_ex),    32'h0);
        chk("rst_taken", 32'(taken_cnt),      32'h0);

        // Counter saturation
        for (int i = 0; i < CMAX + 6; i++) begin
            issue(1, 32'h1000, 32'h10, 32'h0, 0);
            ack_done();
        end
        @(negedge clk);
        chk("sat_taken",  32'(taken_cnt),  32'(CMAX));
        chk("sat_branch", 32'(branch_cnt), 32'(CMAX));

        // Randomized phase against the model
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst          = ($urandom_range(0, 149) == 0);
            ex_valid     = ($urandom_range(0, 3) != 0);
            ex_branch    = $urandom_range(0, 1);
            ex_jal       = ($urandom_range(0, 3) == 0);
            ex_jalr      = ($urandom_range(0, 3) == 0);
            cmp_taken    = $urandom_range(0, 1);
            ex_pc        = $urandom;
            ex_imm       = $urandom;
            ex_rs1       = $urandom;
            stall        = ($urandom_range(0, 3) == 0);
            redirect_ack = ($urandom_range(0, 1) == 1);
        end
        tick();
        clear_ex();
        stall = 0;
        redirect_ack = 0;
        rst = 0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
